// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: scheduler state encoding and Ethernet timing constants.
package eth_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, SEND, IFG} state_t;
    localparam int ETH_MAX_WORDS = 375;
    localparam int ETH_IFG_RMII = 48;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after last+1.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic         valid
);
    logic [W-1:0] j;

    // Scan from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        gnt = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(last) + 1 + i) % N);
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
            end
        end
    end

    assign valid = |req;
endmodule

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin frame source arbiter for the RMII transmitter with IFG enforcement.
// Define ETH_TX_SCHED_STATS_EN to add the frames_o/errors_o statistics counters.
module eth_tx_scheduler
    import eth_tx_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IFG_CYCLES = ETH_IFG_RMII,
    parameter int START_TIMEOUT = 1023,
    parameter int MAX_WORDS = ETH_MAX_WORDS,
    localparam int SW = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*11-1:0]  len_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic [SW-1:0]        sel_o,
    output logic [N_REQ-1:0]     done_o,
    output logic [N_REQ-1:0]     err_o,
    output logic [10:0]          data_count_o,
    output logic                 tx_en_o,
    input  logic                 tx_busy_i
`ifdef ETH_TX_SCHED_STATS_EN
    ,
    output logic [15:0]          frames_o,
    output logic [7:0]           errors_o
`endif
);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t state;
    logic pend, busy_q, pick_valid;
    logic [15:0] cnt;
    logic [SW-1:0] last, pick_idx;
    logic [10:0] pick_len;
    logic [N_REQ-1:0] pick;
    logic [10:0] lens [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign lens[g] = len_i[11*g +: 11];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req(req_i),
        .last(last),
        .gnt(pick),
        .valid(pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        pick_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = SW'(i);
                pick_len = lens[i];
            end
        end
    end

    // sel_o/data_count_o double as the latched index/length between arbitration and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IFG;
            cnt <= 16'(IFG_CYCLES - 1);
            last <= SW'(N_REQ - 1);
            pend <= 1'b0;
            busy_q <= 1'b0;
            grant_o <= '0;
            sel_o <= '0;
            done_o <= '0;
            err_o <= '0;
            data_count_o <= '0;
            tx_en_o <= 1'b0;
        end else begin
            busy_q <= tx_busy_i;
            done_o <= '0;
            err_o <= '0;
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        last <= sel_o;
                        if (data_count_o > 11'(MAX_WORDS)) begin
                            err_o <= ONE << sel_o;
                        end else begin
                            grant_o <= ONE << sel_o;
                            tx_en_o <= 1'b1;
                            cnt <= '0;
                            state <= START;
                        end
                    end else if (pick_valid) begin
                        pend <= 1'b1;
                        sel_o <= pick_idx;
                        data_count_o <= pick_len;
                    end
                end
                START: begin
                    if (busy_q) begin
                        tx_en_o <= 1'b0;
                        state <= SEND;
                    end else if (cnt == 16'(START_TIMEOUT - 1)) begin
                        tx_en_o <= 1'b0;
                        grant_o <= '0;
                        err_o <= ONE << sel_o;
                        cnt <= 16'(IFG_CYCLES - 1);
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SEND: begin
                    if (!busy_q) begin
                        done_o <= grant_o;
                        grant_o <= '0;
                        cnt <= 16'(IFG_CYCLES - 1);
                        state <= IFG;
                    end
                end
                default: begin
                    if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - 16'd1;
                end
            endcase
        end
    end

`ifdef ETH_TX_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_o <= '0;
            errors_o <= '0;
        end else begin
            if (|done_o) frames_o <= frames_o + 16'd1;
            if (|err_o && errors_o != 8'hFF) errors_o <= errors_o + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb_eth_tx_scheduler: directed scoreboard bench for eth_tx_scheduler (N_REQ=2, default timing).
module tb_eth_tx_scheduler;
    localparam int K_GRANT = 0, K_DONE = 1, K_ERR = 2;

    typedef struct {
        int kind;
        int src;
        int len;
    } ev_t;

    ev_t q[$];
    int total = 0;
    int bad = 0;

    logic clk = 1'b0, rst_n = 1'b0, tx_busy_i = 1'b0;
    logic [1:0] req_i = '0;
    logic [21:0] len_i = '0;
    logic [1:0] grant_o, done_o, err_o;
    logic sel_o, tx_en_o;
    logic [10:0] data_count_o;
`ifdef ETH_TX_SCHED_STATS_EN
    logic [15:0] frames_o;
    logic [7:0] errors_o;
`endif

    always #10 clk = ~clk;

    eth_tx_scheduler dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req_i),
        .len_i(len_i),
        .grant_o(grant_o),
        .sel_o(sel_o),
        .done_o(done_o),
        .err_o(err_o),
        .data_count_o(data_count_o),
        .tx_en_o(tx_en_o),
        .tx_busy_i(tx_busy_i)
`ifdef ETH_TX_SCHED_STATS_EN
        ,
        .frames_o(frames_o),
        .errors_o(errors_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit hit(input int what);
        return what == 0 ? tx_en_o : what == 1 ? |done_o : what == 2 ? |err_o : !tx_en_o;
    endfunction

    task automatic wait_for(input int what, input int lim, output int n);
        for (n = 1; n <= lim; n++) begin
            @(posedge clk);
            #1;
            if (hit(what)) return;
        end
        chk($sformatf("wait%0d_timeout", what), 1, 0);
    endtask

    task automatic pop_cmp(input int kind, input logic [1:0] vec);
        ev_t e;
        if (q.size() == 0) begin
            chk("sb_unexpected_event", kind, 99);
            return;
        end
        e = q.pop_front();
        chk("sb_kind", kind, e.kind);
        chk("sb_src_onehot", vec, 1 << e.src);
        if (kind == K_GRANT) begin
            chk("sb_sel", sel_o, e.src);
            chk("sb_len", data_count_o, e.len);
        end
    endtask

    // Monitor: pops one expected event per DUT-presented event.
    initial begin
        logic pt;
        pt = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_en_o && !pt) pop_cmp(K_GRANT, grant_o);
            if (|done_o) pop_cmp(K_DONE, done_o);
            if (|err_o) pop_cmp(K_ERR, err_o);
            pt = tx_en_o;
        end
    end

    task automatic serve(input int src, input int busy_cycles);
        int n;
        q.push_back('{K_DONE, src, 0});
        @(posedge clk);
        #1;
        tx_busy_i = 1'b1;
        repeat (busy_cycles) @(posedge clk);
        #1;
        tx_busy_i = 1'b0;
        wait_for(1, 10, n);
    endtask

    task automatic run_frame(input int src, input int len, input int busy_cycles, input logic [1:0] req_after);
        int n;
        q.push_back('{K_GRANT, src, len});
        wait_for(0, 3000, n);
        req_i = req_after;
        serve(src, busy_cycles);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #25;
        chk("rst_grant", grant_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_count", data_count_o, 0);
        chk("rst_tx_en", tx_en_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("idle_no_tx_en", tx_en_o, 0);

        // Single source, len 10.
        len_i = {11'd0, 11'd10};
        req_i = 2'b01;
        q.push_back('{K_GRANT, 0, 10});
        q.push_back('{K_DONE, 0, 0});
        wait_for(0, 10, n);
        chk("req_to_tx_en", n, 2);
        chk("grant_single", grant_o, 2'b01);
        @(posedge clk);
        #1;
        tx_busy_i = 1'b1;
        wait_for(3, 10, n);
        chk_rng("busy_to_tx_en_drop", n, 1, 2);
        chk("grant_held_send", grant_o, 2'b01);
        repeat (98) @(posedge clk);
        #1;
        tx_busy_i = 1'b0;
        wait_for(1, 10, n);
        chk_rng("busy_fall_to_done", n, 1, 2);
        chk("done_src0", done_o, 2'b01);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done_o, 0);
        chk("grant_dropped", grant_o, 0);
        q.push_back('{K_GRANT, 0, 10});
        wait_for(0, 200, n);
        chk_rng("ifg_gap", n + 1, 48, 52);
        req_i = 2'b11;
        len_i = {11'd7, 11'd5};
        serve(0, 20);

        // Both requesting: strict alternation starting with source 1.
        run_frame(1, 7, 30, 2'b11);
        run_frame(0, 5, 30, 2'b11);
        run_frame(1, 7, 30, 2'b11);
        run_frame(0, 5, 30, 2'b00);

        // Oversize length on source 1 is rejected, then source 0 served.
        len_i = {11'd376, 11'd4};
        q.push_back('{K_ERR, 1, 0});
        req_i = 2'b11;
        wait_for(2, 200, n);
        chk("oversize_err", err_o, 2'b10);
        chk("oversize_no_tx_en", tx_en_o, 0);
        chk("oversize_no_grant", grant_o, 0);
        req_i = 2'b01;
        run_frame(0, 4, 10, 2'b00);

        // Start timeout with busy held low.
        len_i = {11'd0, 11'd3};
        q.push_back('{K_GRANT, 0, 3});
        q.push_back('{K_ERR, 0, 0});
        req_i = 2'b01;
        wait_for(0, 200, n);
        req_i = 2'b00;
        wait_for(3, 1100, n);
        chk("timeout_cycles", n, 1023);
        chk("timeout_err", err_o, 2'b01);
        chk("timeout_grant", grant_o, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("post_timeout_idle", tx_en_o, 0);

        // Reset in the middle of SEND.
        len_i = {11'd9, 11'd0};
        q.push_back('{K_GRANT, 1, 9});
        req_i = 2'b10;
        wait_for(0, 200, n);
        @(posedge clk);
        #1;
        tx_busy_i = 1'b1;
        repeat (10) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", grant_o, 0);
        chk("arst_tx_en", tx_en_o, 0);
        chk("arst_count", data_count_o, 0);
        chk("arst_sel", sel_o, 0);
        tx_busy_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.push_back('{K_GRANT, 1, 9});
        wait_for(0, 200, n);
        chk_rng("post_reset_gap", n, 48, 55);
        req_i = 2'b00;
        serve(1, 10);

`ifdef ETH_TX_SCHED_STATS_EN
        len_i = {11'd0, 11'd4};
        req_i = 2'b01;
        run_frame(0, 4, 10, 2'b01);
        run_frame(0, 4, 10, 2'b01);
        q.push_back('{K_GRANT, 0, 4});
        q.push_back('{K_ERR, 0, 0});
        wait_for(0, 200, n);
        req_i = 2'b00;
        wait_for(2, 1100, n);
        repeat (2) @(posedge clk);
        #1;
        chk("stats_frames", frames_o, 3);
        chk("stats_errors", errors_o, 1);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
